bunki_pred: RTL and testbench

- Parametrised branch-prediction unit for the pipelined CPU; successor to the fixed 16-entry, 12-bit-PC branch unit.
- Generalised in PC width and table depth. Adds a tagged branch-target buffer (BTB), an explicit resolve/flush interface and saturating hit/miss statistics.
- Sits beside the fetch stage: predicts next PC each cycle. The execute stage reports resolved branches back; the block raises flush plus a redirect PC on a mispredict.

---
 rtl/bunki_pred.sv | 121 ++++++++++++
 tb/tb_bunki_pred.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/bunki_pred.sv
// Branch predictor: 2-bit saturating counters, tagged BTB, resolve/flush path and hit/miss statistics.
// Optional gshare indexing of the counter table is enabled by defining BUNKI_PRED_GSHARE_EN.
module bunki_pred #(
    parameter int         PC_W     = 12,
    parameter int         IDX_W    = 4,
    parameter int         TAG_W    = 4,
    parameter logic [1:0] CTR_INIT = 2'b01,
    parameter int         STAT_W   = 16
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              enable,
    input  logic [PC_W-1:0]   fetch_pc,
    output logic              pred_taken,
    output logic [PC_W-1:0]   pred_target,
    output logic [IDX_W-1:0]  pred_idx,
    output logic [PC_W-1:0]   next_pc,
    input  logic              res_valid,
    input  logic [PC_W-1:0]   res_pc,
    input  logic [IDX_W-1:0]  res_idx,
    input  logic              res_taken,
    input  logic [PC_W-1:0]   res_target,
    input  logic              res_pred_taken,
    input  logic [PC_W-1:0]   res_pred_target,
    output logic              flush,
    output logic [PC_W-1:0]   redirect_pc,
    output logic [STAT_W-1:0] br_count,
    output logic [STAT_W-1:0] miss_count
);

    localparam int DEPTH = 1 << IDX_W;

    function automatic logic [1:0] ctr_step(input logic [1:0] c, input logic taken);
        if (taken)
            return (c == 2'b11) ? c : c + 2'b01;
        return (c == 2'b00) ? c : c - 2'b01;
    endfunction

    function automatic logic [STAT_W-1:0] stat_inc(input logic [STAT_W-1:0] s);
        return (&s) ? s : s + STAT_W'(1);
    endfunction

    logic [1:0]       ctr     [DEPTH];
    logic [DEPTH-1:0] btb_v;
    logic [TAG_W-1:0] btb_tag [DEPTH];
    logic [PC_W-1:0]  btb_tgt [DEPTH];

    logic [IDX_W-1:0] bidx;
    logic [IDX_W-1:0] widx;
    logic [TAG_W-1:0] ftag;
    logic [TAG_W-1:0] wtag;
    logic             hit;
    logic             miss;
    logic             upd;
    logic             unused_fetch_hi;

    // Bits above the tag field take no part in the lookup.
    assign unused_fetch_hi = ^fetch_pc;

    assign bidx = fetch_pc[IDX_W-1:0];
    assign ftag = fetch_pc[IDX_W+TAG_W-1:IDX_W];
    assign widx = res_pc[IDX_W-1:0];
    assign wtag = res_pc[IDX_W+TAG_W-1:IDX_W];

`ifdef BUNKI_PRED_GSHARE_EN
    logic [IDX_W-1:0] ghr;
    assign pred_idx = bidx ^ ghr;
`else
    assign pred_idx = bidx;
`endif

    assign hit         = btb_v[bidx] && (btb_tag[bidx] == ftag);
    assign pred_taken  = hit && ctr[pred_idx][1];
    assign pred_target = btb_tgt[bidx];

    // A taken/taken pair with differing targets is still a mispredict.
    assign miss = res_valid &&
                  ((res_taken != res_pred_taken) ||
                   (res_taken && res_pred_taken && (res_target != res_pred_target)));
    assign flush       = miss;
    assign redirect_pc = res_taken ? res_target : res_pc + PC_W'(1);
    assign next_pc     = flush      ? redirect_pc :
                         pred_taken ? pred_target : fetch_pc + PC_W'(1);

    assign upd = enable && res_valid;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++)
                ctr[i] <= CTR_INIT;
            btb_v      <= '0;
            br_count   <= '0;
            miss_count <= '0;
        end else if (upd) begin
            ctr[res_idx] <= ctr_step(ctr[res_idx], res_taken);
            if (res_taken)
                btb_v[widx] <= 1'b1;
            br_count <= stat_inc(br_count);
            if (miss)
                miss_count <= stat_inc(miss_count);
        end
    end

    // Tags and targets are qualified by btb_v, so they need no reset.
    always_ff @(posedge clock) begin
        if (upd && res_taken) begin
            btb_tag[widx] <= wtag;
            btb_tgt[widx] <= res_target;
        end
    end

`ifdef BUNKI_PRED_GSHARE_EN
    always_ff @(posedge clock or negedge reset) begin
        if (!reset)
            ghr <= '0;
        else if (upd)
            ghr <= {ghr[IDX_W-2:0], res_taken};
    end
`endif

endmodule

// File: tb/tb_bunki_pred.sv
// Self-checking bench for bunki_pred: directed literal checks plus randomized traffic against
// a table-level behavioural model compared every cycle.
module tb_bunki_pred;

    localparam int PC_W   = 12;
    localparam int IDX_W  = 4;
    localparam int TAG_W  = 4;
    localparam int STAT_W = 16;

    logic              clock = 1'b0;
    logic              reset = 1'b1;
    logic              enable = 1'b0;
    logic [PC_W-1:0]   fetch_pc = '0;
    logic              pred_taken;
    logic [PC_W-1:0]   pred_target;
    logic [IDX_W-1:0]  pred_idx;
    logic [PC_W-1:0]   next_pc;
    logic              res_valid = 1'b0;
    logic [PC_W-1:0]   res_pc = '0;
    logic [IDX_W-1:0]  res_idx = '0;
    logic              res_taken = 1'b0;
    logic [PC_W-1:0]   res_target = '0;
    logic              res_pred_taken = 1'b0;
    logic [PC_W-1:0]   res_pred_target = '0;
    logic              flush;
    logic [PC_W-1:0]   redirect_pc;
    logic [STAT_W-1:0] br_count;
    logic [STAT_W-1:0] miss_count;

    bunki_pred #(.PC_W(PC_W), .IDX_W(IDX_W), .TAG_W(TAG_W), .CTR_INIT(2'b01), .STAT_W(STAT_W)) dut (
        .clock(clock), .reset(reset), .enable(enable), .fetch_pc(fetch_pc),
        .pred_taken(pred_taken), .pred_target(pred_target), .pred_idx(pred_idx), .next_pc(next_pc),
        .res_valid(res_valid), .res_pc(res_pc), .res_idx(res_idx), .res_taken(res_taken),
        .res_target(res_target), .res_pred_taken(res_pred_taken), .res_pred_target(res_pred_target),
        .flush(flush), .redirect_pc(redirect_pc), .br_count(br_count), .miss_count(miss_count)
    );

    always #5 clock = ~clock;

    int n_tests = 0;
    int n_fail  = 0;
    bit chk_en  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: whole-table state as plain integers.
    int m_ctr [16];
    bit m_v   [16];
    int m_tag [16];
    int m_tgt [16];
    int m_br;
    int m_miss;
    int m_ghr;

    function automatic bit model_miss();
        if (!res_valid) return 0;
        if (res_taken != res_pred_taken) return 1;
        return res_taken && (res_target != res_pred_target);
    endfunction

    always @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < 16; i++) begin
                m_ctr[i] = 1;
                m_v[i]   = 0;
            end
            m_br = 0; m_miss = 0; m_ghr = 0;
        end else if (enable && res_valid) begin
            if (model_miss()) m_miss = (m_miss == 65535) ? m_miss : m_miss + 1;
            m_br = (m_br == 65535) ? m_br : m_br + 1;
            if (res_taken) begin
                m_ctr[res_idx] = (m_ctr[res_idx] >= 3) ? 3 : m_ctr[res_idx] + 1;
                m_v[res_pc % 16]   = 1;
                m_tag[res_pc % 16] = (res_pc / 16) % 16;
                m_tgt[res_pc % 16] = res_target;
            end else begin
                m_ctr[res_idx] = (m_ctr[res_idx] <= 0) ? 0 : m_ctr[res_idx] - 1;
            end
            m_ghr = ((m_ghr * 2) + res_taken) % 16;
        end
    end

    always @(negedge clock) begin : compare
        int  bidx, pidx, redir, nxt;
        bit  hit, ptk, mis;
        if (chk_en && reset) begin
            bidx = fetch_pc % 16;
`ifdef BUNKI_PRED_GSHARE_EN
            pidx = bidx ^ m_ghr;
`else
            pidx = bidx;
`endif
            hit   = m_v[bidx] && (m_tag[bidx] == (fetch_pc / 16) % 16);
            ptk   = hit && (m_ctr[pidx] >= 2);
            mis   = model_miss();
            redir = res_taken ? int'(res_target) : (int'(res_pc) + 1) % 4096;
            nxt   = mis ? redir : ptk ? m_tgt[bidx] : (int'(fetch_pc) + 1) % 4096;
            check("m_pred_idx", 32'(pred_idx), 32'(pidx));
            check("m_pred_taken", 32'(pred_taken), 32'(ptk));
            if (hit) check("m_pred_target", 32'(pred_target), 32'(m_tgt[bidx]));
            check("m_next_pc", 32'(next_pc), 32'(nxt));
            check("m_flush", 32'(flush), 32'(mis));
            check("m_redirect_pc", 32'(redirect_pc), 32'(redir));
            check("m_br_count", 32'(br_count), 32'(m_br));
            check("m_miss_count", 32'(miss_count), 32'(m_miss));
        end
    end

    task automatic drive(input logic en, input logic [11:0] fpc, input logic rv, input logic [11:0] rpc,
                         input logic rt, input logic [11:0] rtgt, input logic rpt, input logic [11:0] rptgt);
        enable = en; fetch_pc = fpc; res_valid = rv; res_pc = rpc; res_idx = rpc[3:0];
        res_taken = rt; res_target = rtgt; res_pred_taken = rpt; res_pred_target = rptgt;
        #1;
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    initial begin
        #2 reset = 1'b0;
        repeat (2) @(posedge clock);
        #1 reset = 1'b1;
        chk_en = 1;

        drive(1, 12'h010, 0, 0, 0, 0, 0, 0);
        check("rst_pred_taken", 32'(pred_taken), 0);
        check("rst_next_pc", 32'(next_pc), 32'h011);
        check("rst_flush", 32'(flush), 0);
        check("rst_br_count", 32'(br_count), 0);
        step();

        drive(1, 12'h010, 1, 12'h010, 1, 12'h020, 0, 12'h000);
        check("first_flush", 32'(flush), 1);
        check("first_redirect", 32'(redirect_pc), 32'h020);
        step();
        drive(1, 12'h010, 0, 0, 0, 0, 0, 0);
        check("first_pred_taken", 32'(pred_taken), 1);
        check("first_next_pc", 32'(next_pc), 32'h020);
        step();

        for (int i = 0; i < 6; i++) begin
            drive(1, 12'h000, 1, 12'h005, 1, 12'h050, 1, 12'h050);
            step();
        end
        drive(1, 12'h005, 1, 12'h005, 0, 12'h000, 1, 12'h050);
        check("sat_pred_taken", 32'(pred_taken), 1);
        check("sat_nt_flush", 32'(flush), 1);
        check("sat_nt_redirect", 32'(redirect_pc), 32'h006);
        step();
        drive(1, 12'h005, 1, 12'h005, 0, 12'h000, 1, 12'h050);
        check("ctr10_pred_taken", 32'(pred_taken), 1);
        step();
        drive(1, 12'h005, 0, 0, 0, 0, 0, 0);
        check("ctr01_pred_taken", 32'(pred_taken), 0);
        check("ctr01_next_pc", 32'(next_pc), 32'h006);
        step();

        drive(1, 12'h000, 1, 12'h013, 1, 12'h100, 0, 0);
        step();
        drive(1, 12'h033, 0, 0, 0, 0, 0, 0);
        check("alias_pred_taken", 32'(pred_taken), 0);
        check("alias_next_pc", 32'(next_pc), 32'h034);
        step();
        drive(1, 12'h000, 1, 12'h033, 1, 12'h200, 0, 0);
        step();
        drive(1, 12'h013, 0, 0, 0, 0, 0, 0);
        check("evicted_pred_taken", 32'(pred_taken), 0);
        check("evicted_next_pc", 32'(next_pc), 32'h014);
        step();
        drive(1, 12'h033, 0, 0, 0, 0, 0, 0);
        check("owner_next_pc", 32'(next_pc), 32'h200);
        step();

        drive(1, 12'hFFF, 0, 0, 0, 0, 0, 0);
        check("wrap_next_pc", 32'(next_pc), 32'h000);
        step();
        drive(1, 12'h000, 1, 12'h033, 1, 12'h300, 1, 12'h200);
        check("tgt_miss_flush", 32'(flush), 1);
        check("tgt_miss_redirect", 32'(redirect_pc), 32'h300);
        step();
        drive(1, 12'h000, 0, 0, 0, 0, 0, 0);
        check("tgt_miss_count", 32'(miss_count), 6);
        check("tgt_br_count", 32'(br_count), 12);
        step();

        drive(0, 12'h010, 1, 12'h0A0, 1, 12'h0B0, 0, 0);
        check("hold_flush", 32'(flush), 1);
        check("hold_next_pc", 32'(next_pc), 32'h0B0);
        step();
        drive(1, 12'h0A0, 0, 0, 0, 0, 0, 0);
        check("hold_btb_next_pc", 32'(next_pc), 32'h0A1);
        check("hold_br_count", 32'(br_count), 12);
        check("hold_miss_count", 32'(miss_count), 6);
        step();
        drive(1, 12'h010, 0, 0, 0, 0, 0, 0);
        check("hold_ctr_next_pc", 32'(next_pc), 32'h020);
        step();

        for (int i = 0; i < 400; i++) begin
            logic [11:0] fpc, rpc, rtgt;
            logic        rt;
            if (i == 200) begin
                @(posedge clock);
                #3 reset = 1'b0;
                #1;
                check("async_br_count", 32'(br_count), 0);
                check("async_miss_count", 32'(miss_count), 0);
                check("async_pred_taken", 32'(pred_taken), 0);
                @(posedge clock);
                #1 reset = 1'b1;
            end
            fpc  = ($urandom_range(0, 9) == 0) ? 12'hFFF : 12'(($urandom_range(0, 3) << 4) | $urandom_range(0, 15));
            rpc  = 12'(($urandom_range(0, 3) << 4) | $urandom_range(0, 15));
            rtgt = 12'($urandom_range(0, 4095));
            rt   = 1'($urandom_range(0, 1));
            drive(1'($urandom_range(0, 7) != 0), fpc, 1'($urandom_range(0, 1)), rpc, rt, rtgt,
                  1'($urandom_range(0, 1)), ($urandom_range(0, 2) == 0) ? 12'($urandom_range(0, 4095)) : rtgt);
            if ($urandom_range(0, 7) == 0) res_idx = 4'($urandom_range(0, 15));
            step();
        end

        repeat (2) @(posedge clock);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
